ddr_wr_arb: RTL



---
 rtl/ddr_wr_arb_if.sv | 43 ++++
 rtl/ddr_wr_arb.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ddr_wr_arb_if.sv
// ddr_wr_arb_if: write-beat bus between the two requesters, the arbiter and
// the DDR controller write port. The "master" modport is the side that
// drives requester beats and the DDR accept; the "slave" modport is the
// arbiter itself.
interface ddr_wr_arb_if #(
  parameter int MEM_ADDRBITS = 28,
  parameter int MEM_WIDTH    = 128
);
  logic [MEM_ADDRBITS-1:0] i_r0_waddr;
  logic [MEM_WIDTH-1:0]    i_r0_wdata;
  logic                    i_r0_wdata_have;
  logic                    i_r0_lock;
  logic                    o_r0_wdata_accept;

  logic [MEM_ADDRBITS-1:0] i_r1_waddr;
  logic [MEM_WIDTH-1:0]    i_r1_wdata;
  logic                    i_r1_wdata_have;
  logic                    i_r1_lock;
  logic                    o_r1_wdata_accept;

  logic [MEM_ADDRBITS-1:0] o_ddr_waddr;
  logic [MEM_WIDTH-1:0]    o_ddr_wdata;
  logic                    o_ddr_wdata_have;
  logic                    i_ddr_wdata_accept;

  logic [1:0]              o_grant;

  modport master (
    output i_r0_waddr, i_r0_wdata, i_r0_wdata_have, i_r0_lock,
    output i_r1_waddr, i_r1_wdata, i_r1_wdata_have, i_r1_lock,
    output i_ddr_wdata_accept,
    input  o_r0_wdata_accept, o_r1_wdata_accept,
    input  o_ddr_waddr, o_ddr_wdata, o_ddr_wdata_have, o_grant
  );

  modport slave (
    input  i_r0_waddr, i_r0_wdata, i_r0_wdata_have, i_r0_lock,
    input  i_r1_waddr, i_r1_wdata, i_r1_wdata_have, i_r1_lock,
    input  i_ddr_wdata_accept,
    output o_r0_wdata_accept, o_r1_wdata_accept,
    output o_ddr_waddr, o_ddr_wdata, o_ddr_wdata_have, o_grant
  );
endinterface

// File: rtl/ddr_wr_arb.sv
// ddr_wr_arb: two-requester arbiter for the single DDR write port.
// Requester 0 is the problem loader, requester 1 the result write-back.
// Grants rotate per beat; a requester may hold the port with its lock bit
// for at most MAX_LOCK_BEATS consecutive accepted beats.
// Optional feature macro: DDR_WR_ARB_OUTREG_EN -- when defined, a one-entry
// registered stage drives o_ddr_* so no requester input reaches the DDR
// outputs combinationally. Default (undefined) forwards combinationally.
module ddr_wr_arb #(
  parameter int MAX_LOCK_BEATS = 16
) (
  input  logic        i_clk150,
  input  logic        i_reset,
  ddr_wr_arb_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT0 = 2'd1,
    S_GRANT1 = 2'd2
  } state_t;

  localparam logic [8:0] LOCK_LIMIT = 9'(MAX_LOCK_BEATS);

  state_t     state;
  state_t     other_state;
  logic       last_served;
  logic [7:0] lock_cnt;
  logic [8:0] lock_next;
  logic [1:0] other_grant;
  logic       own_have;
  logic       own_lock;
  logic       other_have;
  logic       own_acc;
  logic       beat_ok;

  assign lock_next = {1'b0, lock_cnt} + 9'd1;

  // Resolve which requester is the current owner and which one is waiting.
  always_comb begin
    own_have    = 1'b0;
    own_lock    = 1'b0;
    other_have  = 1'b0;
    other_state = S_IDLE;
    other_grant = 2'b00;
    case (state)
      S_GRANT0: begin
        own_have    = bus.i_r0_wdata_have;
        own_lock    = bus.i_r0_lock;
        other_have  = bus.i_r1_wdata_have;
        other_state = S_GRANT1;
        other_grant = 2'b10;
      end
      S_GRANT1: begin
        own_have    = bus.i_r1_wdata_have;
        own_lock    = bus.i_r1_lock;
        other_have  = bus.i_r0_wdata_have;
        other_state = S_GRANT0;
        other_grant = 2'b01;
      end
      default: ;
    endcase
  end

  assign own_acc = own_have & beat_ok;
  assign bus.o_r0_wdata_accept = own_acc & (state == S_GRANT0);
  assign bus.o_r1_wdata_accept = own_acc & (state == S_GRANT1);

  // Arbitration FSM: owner selection, lock run counting and the debug grant.
  always_ff @(posedge i_clk150) begin
    if (i_reset) begin
      state       <= S_IDLE;
      last_served <= 1'b1;
      lock_cnt    <= '0;
      bus.o_grant <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_r0_wdata_have && (!bus.i_r1_wdata_have || last_served)) begin
            state       <= S_GRANT0;
            bus.o_grant <= 2'b01;
          end else if (bus.i_r1_wdata_have) begin
            state       <= S_GRANT1;
            bus.o_grant <= 2'b10;
          end
        end
        S_GRANT0, S_GRANT1: begin
          if (own_acc) begin
            last_served <= (state == S_GRANT1);
            if (own_lock && (lock_next < LOCK_LIMIT)) begin
              lock_cnt <= lock_next[7:0];
            end else begin
              lock_cnt <= '0;
              if (other_have) begin
                state       <= other_state;
                bus.o_grant <= other_grant;
              end
            end
          end else if (!own_have) begin
            lock_cnt <= '0;
            if (other_have) begin
              state       <= other_state;
              bus.o_grant <= other_grant;
            end else begin
              state       <= S_IDLE;
              bus.o_grant <= 2'b00;
            end
          end
        end
        default: begin
          state       <= S_IDLE;
          bus.o_grant <= 2'b00;
        end
      endcase
    end
  end

`ifdef DDR_WR_ARB_OUTREG_EN
  assign beat_ok = ~bus.o_ddr_wdata_have | bus.i_ddr_wdata_accept;

  // One-entry output stage: loads the accepted beat, empties on DDR accept.
  always_ff @(posedge i_clk150) begin
    if (i_reset) begin
      bus.o_ddr_wdata_have <= 1'b0;
      bus.o_ddr_waddr      <= '0;
      bus.o_ddr_wdata      <= '0;
    end else if (own_acc) begin
      bus.o_ddr_wdata_have <= 1'b1;
      bus.o_ddr_waddr      <= (state == S_GRANT1) ? bus.i_r1_waddr : bus.i_r0_waddr;
      bus.o_ddr_wdata      <= (state == S_GRANT1) ? bus.i_r1_wdata : bus.i_r0_wdata;
    end else if (bus.i_ddr_wdata_accept) begin
      bus.o_ddr_wdata_have <= 1'b0;
      bus.o_ddr_waddr      <= '0;
      bus.o_ddr_wdata      <= '0;
    end
  end
`else
  assign beat_ok = bus.i_ddr_wdata_accept;

  // Combinational forwarding of the owner's beat; zeros when nobody owns.
  always_comb begin
    bus.o_ddr_wdata_have = own_have;
    bus.o_ddr_waddr      = '0;
    bus.o_ddr_wdata      = '0;
    if (state == S_GRANT0) begin
      bus.o_ddr_waddr = bus.i_r0_waddr;
      bus.o_ddr_wdata = bus.i_r0_wdata;
    end else if (state == S_GRANT1) begin
      bus.o_ddr_waddr = bus.i_r1_waddr;
      bus.o_ddr_wdata = bus.i_r1_wdata;
    end
  end
`endif

endmodule
